wb_bus_arbiter: RTL and testbench

- Two-master to one-slave Wishbone B4 classic arbiter.
- Lets the core's instruction port and data port share one single-ported memory or peripheral bus.
- Sits between the core and a single-port RAM in the CPU testbench and in SoC tops.
- Round-robin grant, held for the whole cycle (cyc); a watchdog converts a hung slave access into a bus error.

---
 rtl/wb_bus_arbiter_pkg.sv | 19 +
 rtl/wb_bus_arbiter_if.sv | 28 ++
 rtl/wb_watchdog.sv | 49 ++++
 rtl/wb_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_bus_arbiter_pkg;

    localparam int unsigned WB_SEL_W = 4;
    localparam int unsigned WB_DAT_W = 32;
    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// One Wishbone B4 classic link; master drives the request, slave drives the response.
interface wb_bus_arbiter_if
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] adr;
    logic [WB_DAT_W-1:0]   dat_w;
    logic [WB_DAT_W-1:0]   dat_r;
    logic [WB_SEL_W-1:0]   sel;
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic                  ack;
    logic                  err;

    modport master (
        output adr, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_watchdog.sv
// Counts stalled strobe cycles and emits a one-cycle timeout pulse; TIMEOUT_CYCLES=0 disables it.
module wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic ack_i,
    input  logic err_i,
    input  logic clear_i,
    output logic timeout_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk_i, rst_ni, stb_i, ack_i, err_i, clear_i};
            assign timeout_o = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             stall;

            assign stall     = stb_i && !ack_i && !err_i;
            assign timeout_o = stall && (cnt_q == LAST);

            // Saturating so a misconfigured bus can never wrap back into a false timeout.
            always_comb begin
                cnt_d = cnt_q;
                if (clear_i || !stall || timeout_o) begin
                    cnt_d = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter letting the instruction and data masters share one Wishbone slave.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    wb_bus_arbiter_if.slave       iwbs,
    wb_bus_arbiter_if.slave       dwbs,
    wb_bus_arbiter_if.master      wbm
);

    state_e state_q, state_d;
    grant_e last_q, last_d;

    logic [ADDR_WIDTH-1:0] m_adr;
    logic [WB_DAT_W-1:0]   m_dat;
    logic [WB_SEL_W-1:0]   m_sel;
    logic                  m_cyc;
    logic                  m_we;
    logic                  own_stb;
    logic                  timeout;
    logic                  ack_g;
    logic                  err_g;
    logic                  unused_i;

    // The instruction port is read-only, so its write-side fields are ignored.
    assign unused_i = ^{iwbs.dat_w, iwbs.sel, iwbs.we};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= GRANT_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (iwbs.cyc && dwbs.cyc) begin
                    if (last_q == GRANT_I) begin
                        state_d = GNT_D;
                        last_d  = GRANT_D;
                    end else begin
                        state_d = GNT_I;
                        last_d  = GRANT_I;
                    end
                end else if (iwbs.cyc) begin
                    state_d = GNT_I;
                    last_d  = GRANT_I;
                end else if (dwbs.cyc) begin
                    state_d = GNT_D;
                    last_d  = GRANT_D;
                end
            end
            GNT_I:   if (!iwbs.cyc) state_d = IDLE;
            GNT_D:   if (!dwbs.cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner mux is driven from the registered state, so reset clears the bus without a clock.
    always_comb begin
        m_adr   = '0;
        m_dat   = '0;
        m_sel   = '0;
        m_cyc   = 1'b0;
        m_we    = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            GNT_I: begin
                m_adr   = iwbs.adr;
                m_sel   = WB_SEL_ALL;
                m_cyc   = iwbs.cyc;
                own_stb = iwbs.stb;
            end
            GNT_D: begin
                m_adr   = dwbs.adr;
                m_dat   = dwbs.dat_w;
                m_sel   = dwbs.sel;
                m_cyc   = dwbs.cyc;
                m_we    = dwbs.we;
                own_stb = dwbs.stb;
            end
            default: ;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .stb_i     (own_stb),
        .ack_i     (wbm.ack),
        .err_i     (wbm.err),
        .clear_i   (state_d != state_q),
        .timeout_o (timeout)
    );

    assign wbm.adr   = m_adr;
    assign wbm.dat_w = m_dat;
    assign wbm.sel   = m_sel;
    assign wbm.cyc   = m_cyc;
    assign wbm.we    = m_we;
    assign wbm.stb   = own_stb && !timeout;

    // A slave error overrides a simultaneous ack; the watchdog only fires when no ack is present.
    assign ack_g = own_stb && wbm.ack && !wbm.err;
    assign err_g = (own_stb && wbm.err) || timeout;

    assign iwbs.ack   = (state_q == GNT_I) && ack_g;
    assign iwbs.err   = (state_q == GNT_I) && err_g;
    assign dwbs.ack   = (state_q == GNT_D) && ack_g;
    assign dwbs.err   = (state_q == GNT_D) && err_g;
    assign iwbs.dat_r = wbm.dat_r;
    assign dwbs.dat_r = wbm.dat_r;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: vector table plus multi-cycle sequences against a small RAM model.
module tb_wb_bus_arbiter;

    localparam logic [31:0] I_ADDR = 32'h0000_0100;
    localparam logic [31:0] D_ADDR = 32'h8000_0010;

    logic clk;
    logic rst_n;

    wb_bus_arbiter_if #(.ADDR_WIDTH(32)) iwbs ();
    wb_bus_arbiter_if #(.ADDR_WIDTH(32)) dwbs ();
    wb_bus_arbiter_if #(.ADDR_WIDTH(32)) wbm ();

    wb_bus_arbiter #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .iwbs   (iwbs),
        .dwbs   (dwbs),
        .wbm    (wbm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Slave side: either a directly driven ack/err, or an ack-next-cycle RAM.
    logic        ram_mode;
    logic        ack_drv, err_drv;
    logic        ram_ack;
    logic [31:0] ram_dat;
    logic [31:0] mem [16];

    assign wbm.ack   = ram_mode ? ram_ack : ack_drv;
    assign wbm.err   = ram_mode ? 1'b0 : err_drv;
    assign wbm.dat_r = ram_dat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ack <= 1'b0;
            ram_dat <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1122_3344;
        end else begin
            ram_ack <= wbm.cyc && wbm.stb && !ram_ack;
            if (wbm.cyc && wbm.stb && !ram_ack) begin
                ram_dat <= mem[wbm.adr[5:2]];
                if (wbm.we) begin
                    for (int b = 0; b < 4; b++)
                        if (wbm.sel[b]) mem[wbm.adr[5:2]][8*b +: 8] <= wbm.dat_w[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input bit is_d, input string name);
        int k = 0;
        while (!(is_d ? dwbs.ack : iwbs.ack) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, 128'(is_d ? dwbs.ack : iwbs.ack), 128'(1));
    endtask

    task automatic run_master(input bit is_d, input int n);
        for (int t = 0; t < n; t++) begin
            if (is_d) begin dwbs.cyc = 1'b1; dwbs.stb = 1'b1; end
            else      begin iwbs.cyc = 1'b1; iwbs.stb = 1'b1; end
            wait_ack(is_d, is_d ? "contend_d_ack" : "contend_i_ack");
            if (is_d) begin dwbs.cyc = 1'b0; dwbs.stb = 1'b0; end
            else      begin iwbs.cyc = 1'b0; iwbs.stb = 1'b0; end
            @(negedge clk);
        end
    endtask

    // Grant-order monitor: records the owner at each rising wbm_cyc and flags acks to the wrong master.
    logic mon_en;
    int   grants[$];
    int   viol;
    logic prev_cyc;

    initial begin
        prev_cyc = 1'b0;
        viol     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (wbm.cyc && !prev_cyc) grants.push_back(wbm.adr == D_ADDR ? 2 : 1);
                if (wbm.cyc && wbm.adr == D_ADDR && iwbs.ack) viol++;
                if (wbm.cyc && wbm.adr == I_ADDR && dwbs.ack) viol++;
            end
            prev_cyc = wbm.cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    typedef struct packed {
        logic [5:0] stim;   // icyc istb dcyc dstb ack err
        logic [1:0] own;    // 0 none, 1 instruction, 2 data
        logic [5:0] exp;    // cyc stb iack ierr dack derr
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] exp_adr;
    int          acks, dack_bad, k;

    initial begin
        tbl[0]  = '{6'b111110, 2'd2, 6'b110010};
        tbl[1]  = '{6'b110000, 2'd2, 6'b000000};
        tbl[2]  = '{6'b110010, 2'd0, 6'b000000};
        tbl[3]  = '{6'b111100, 2'd1, 6'b110000};
        tbl[4]  = '{6'b111111, 2'd1, 6'b110100};
        tbl[5]  = '{6'b100010, 2'd1, 6'b100000};
        tbl[6]  = '{6'b001100, 2'd1, 6'b000000};
        tbl[7]  = '{6'b001100, 2'd0, 6'b000000};
        tbl[8]  = '{6'b001110, 2'd2, 6'b110010};
        tbl[9]  = '{6'b110000, 2'd2, 6'b000000};
        tbl[10] = '{6'b111100, 2'd0, 6'b000000};
        tbl[11] = '{6'b111110, 2'd1, 6'b111000};
        tbl[12] = '{6'b111101, 2'd1, 6'b110100};

        mon_en     = 1'b0;
        ram_mode   = 1'b0;
        ack_drv    = 1'b1;
        err_drv    = 1'b0;
        iwbs.adr   = I_ADDR; iwbs.dat_w = '0; iwbs.sel = '0; iwbs.we = 1'b0;
        iwbs.cyc   = 1'b1;   iwbs.stb   = 1'b1;
        dwbs.adr   = D_ADDR; dwbs.dat_w = '0; dwbs.sel = 4'hF; dwbs.we = 1'b0;
        dwbs.cyc   = 1'b1;   dwbs.stb   = 1'b1;
        rst_n      = 1'b0;

        // Reset held with both masters requesting and a stray slave ack.
        repeat (3) @(negedge clk);
        check("reset_bus", {wbm.adr, wbm.dat_w, wbm.sel, wbm.cyc, wbm.stb, wbm.we}, '0);
        check("reset_resp", {iwbs.ack, iwbs.err, dwbs.ack, dwbs.err}, '0);
        rst_n   = 1'b1;
        ack_drv = 1'b0;
        #1 check("release_idle", {wbm.cyc, wbm.adr}, '0);
        @(negedge clk);
        check("first_grant_d", {wbm.cyc, wbm.adr}, {1'b1, D_ADDR});

        for (int i = 0; i < 13; i++) begin
            {iwbs.cyc, iwbs.stb, dwbs.cyc, dwbs.stb, ack_drv, err_drv} = tbl[i].stim;
            exp_adr = (tbl[i].own == 2'd1) ? I_ADDR : (tbl[i].own == 2'd2) ? D_ADDR : 32'h0;
            #1 check($sformatf("vec%0d", i),
                     {wbm.adr, wbm.cyc, wbm.stb, iwbs.ack, iwbs.err, dwbs.ack, dwbs.err},
                     {exp_adr, tbl[i].exp});
            @(negedge clk);
        end
        {iwbs.cyc, iwbs.stb, dwbs.cyc, dwbs.stb, ack_drv, err_drv} = '0;
        repeat (2) @(negedge clk);

        // Watchdog: stalled slave errors on the 4th cycle, then an ack on the 4th cycle wins.
        dwbs.cyc = 1'b1; dwbs.stb = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            #1 check($sformatf("wdog_stall%0d", c), {dwbs.err, dwbs.ack, wbm.stb, wbm.cyc},
                     {c == 4, 1'b0, c != 4, 1'b1});
            @(negedge clk);
        end
        for (int c = 1; c <= 4; c++) begin
            ack_drv = (c == 4);
            #1 check($sformatf("wdog_ack%0d", c), {dwbs.err, dwbs.ack, wbm.stb},
                     {1'b0, c == 4, 1'b1});
            @(negedge clk);
        end
        ack_drv = 1'b0; dwbs.cyc = 1'b0; dwbs.stb = 1'b0;
        repeat (2) @(negedge clk);

        // Write passthrough, then an instruction read of the merged word.
        ram_mode   = 1'b1;
        dwbs.dat_w = 32'hDEAD_BEEF; dwbs.sel = 4'b0011; dwbs.we = 1'b1;
        dwbs.cyc   = 1'b1; dwbs.stb = 1'b1;
        @(negedge clk);
        check("write_pass", {wbm.adr, wbm.dat_w, wbm.sel, wbm.we, wbm.cyc, wbm.stb},
              {D_ADDR, 32'hDEAD_BEEF, 4'b0011, 3'b111});
        wait_ack(1'b1, "write_ack");
        dwbs.cyc = 1'b0; dwbs.stb = 1'b0; dwbs.we = 1'b0;
        repeat (2) @(negedge clk);

        iwbs.adr = D_ADDR; iwbs.cyc = 1'b1; iwbs.stb = 1'b1;
        @(negedge clk);
        check("iread_fields", {wbm.dat_w, wbm.sel, wbm.we}, {32'h0, 4'hF, 1'b0});
        wait_ack(1'b0, "iread_ack");
        check("iread_data", {iwbs.dat_r, dwbs.dat_r}, {32'h1122_BEEF, 32'h1122_BEEF});
        iwbs.cyc = 1'b0; iwbs.stb = 1'b0; iwbs.adr = I_ADDR;
        dwbs.sel = 4'hF;
        repeat (2) @(negedge clk);

        // Contention: alternating single reads from both masters.
        mon_en = 1'b1;
        fork
            run_master(1'b1, 3);
            run_master(1'b0, 3);
        join
        @(negedge clk);
        mon_en = 1'b0;
        check("grant_count", 128'(grants.size()), 128'(6));
        for (int g = 0; g < 6 && g < grants.size(); g++)
            check($sformatf("grant_order%0d", g), 128'(grants[g]), 128'((g % 2 == 0) ? 2 : 1));
        check("wrong_owner_ack", 128'(viol), 128'(0));

        // Burst hold: 8 instruction acks while the data master waits.
        iwbs.cyc = 1'b1; iwbs.stb = 1'b1;
        @(negedge clk);
        dwbs.cyc = 1'b1; dwbs.stb = 1'b1;
        acks = 0; dack_bad = 0; k = 0;
        do begin
            @(negedge clk);
            k++;
            if (iwbs.ack) acks++;
            if (dwbs.ack) dack_bad++;
        end while (acks < 8 && k < 64);
        iwbs.cyc = 1'b0; iwbs.stb = 1'b0;
        check("burst_acks", 128'(acks), 128'(8));
        check("burst_no_dack", 128'(dack_bad), 128'(0));
        @(negedge clk);
        check("burst_idle_gap", {wbm.cyc, wbm.adr}, '0);
        @(negedge clk);
        check("burst_then_d", {wbm.cyc, wbm.adr}, {1'b1, D_ADDR});
        wait_ack(1'b1, "burst_d_ack");
        dwbs.cyc = 1'b0; dwbs.stb = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an instruction access with the slave ack about to arrive.
        iwbs.cyc = 1'b1; iwbs.stb = 1'b1;
        @(negedge clk);
        check("midrst_granted", {wbm.cyc, wbm.stb}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("midrst_async_drop", {wbm.cyc, wbm.stb, iwbs.ack}, '0);
        @(negedge clk);
        check("midrst_no_ack", {iwbs.ack, iwbs.err, wbm.cyc}, '0);
        iwbs.cyc = 1'b0; iwbs.stb = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
